neuron_update_scheduler: RTL

// Shares one potential_adder (FP32 add + threshold compare) among N neurons of a core.

---
 rtl/neuron_update_scheduler_if.sv | 32 +++
 rtl/neuron_update_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/neuron_update_scheduler_if.sv
// Bus bundle for neuron_update_scheduler: event ingress, spike egress and
// the shared potential_adder operand/result wires.
// The slave modport is the scheduler's view. The master modport is the
// view of the surrounding fabric: NoC ports plus the adder.
interface neuron_update_scheduler_if #(
  parameter int unsigned IDW = 4
);
  logic           ev_valid;
  logic           ev_ready;
  logic [IDW-1:0] ev_id;
  logic [31:0]    ev_weight;

  logic [31:0]    add_weight;
  logic [31:0]    add_decayed;
  logic [31:0]    add_thresh;
  logic [31:0]    add_potential;
  logic           add_spike;

  logic           spk_valid;
  logic           spk_ready;
  logic [IDW-1:0] spk_id;

  modport master (
    output ev_valid, ev_id, ev_weight, add_potential, add_spike, spk_ready,
    input  ev_ready, add_weight, add_decayed, add_thresh, spk_valid, spk_id
  );

  modport slave (
    input  ev_valid, ev_id, ev_weight, add_potential, add_spike, spk_ready,
    output ev_ready, add_weight, add_decayed, add_thresh, spk_valid, spk_id
  );
endinterface

// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: time-shares one combinational FP32 potential adder
// across N_NEURONS membrane potentials.
// Incoming weighted events are accumulated one at a time. A timestep pulse
// starts a sweep that applies the leak to every neuron. During the sweep,
// each neuron that fires is reported on the spike port and reset to V_RESET.
// Optional feature: define SPIKE_COUNT_EN to add the spike_count output.
// spike_count holds the number of spikes issued by the most recent sweep.
module neuron_update_scheduler #(
  parameter int unsigned N_NEURONS = 16,
  parameter logic [31:0] LEAK      = 32'hBF800000,
  parameter logic [31:0] V_RESET   = 32'h00000000,
  parameter logic [31:0] V_THRESH  = 32'h41200000,
  localparam int unsigned IDW      = $clog2(N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  timestep,
  output logic                  busy,
`ifdef SPIKE_COUNT_EN
  output logic [IDW:0]          spike_count,
`endif
  neuron_update_scheduler_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAcc   = 2'd1;
  localparam logic [1:0] StSweep = 2'd2;
  localparam logic [1:0] StEmit  = 2'd3;

  logic [1:0]     state_q;
  logic [IDW-1:0] idx_q;
  logic [IDW-1:0] id_q;
  logic [31:0]    weight_q;
  logic [31:0]    pot_q [N_NEURONS];
  logic           spk_valid_q;
  logic [IDW-1:0] spk_id_q;
  logic           sweep_pending_q;
  logic [IDW:0]   count_q;
  logic           last_idx;
  logic           sweep_req;

  assign last_idx  = (idx_q == IDW'(N_NEURONS - 1));
  assign sweep_req = sweep_pending_q | timestep;

  // A sweep request in IDLE wins over an event offered in the same cycle.
  assign bus.ev_ready   = (state_q == StIdle) && !sweep_req;
  assign bus.add_thresh = V_THRESH;
  assign bus.spk_valid  = spk_valid_q;
  assign bus.spk_id     = spk_id_q;
  assign busy           = (state_q != StIdle);

`ifdef SPIKE_COUNT_EN
  assign spike_count = count_q;
`endif

  // Adder operand steering; the operands are zero whenever the adder is idle.
  always_comb begin
    bus.add_weight  = 32'd0;
    bus.add_decayed = 32'd0;
    case (state_q)
      StAcc: begin
        bus.add_weight  = weight_q;
        bus.add_decayed = pot_q[id_q];
      end
      StSweep: begin
        bus.add_weight  = LEAK;
        bus.add_decayed = pot_q[idx_q];
      end
      default: ;
    endcase
  end

  // Scheduler FSM, potential storage and spike output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      id_q            <= '0;
      weight_q        <= 32'd0;
      spk_valid_q     <= 1'b0;
      spk_id_q        <= '0;
      sweep_pending_q <= 1'b0;
      count_q         <= '0;
      for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= V_RESET;
    end else begin
      // A pulse that arrives while busy is remembered and merged with later pulses.
      if (state_q != StIdle && timestep) sweep_pending_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (sweep_req) begin
            state_q         <= StSweep;
            idx_q           <= '0;
            sweep_pending_q <= 1'b0;
            count_q         <= '0;
          end else if (bus.ev_valid) begin
            id_q     <= bus.ev_id;
            weight_q <= bus.ev_weight;
            state_q  <= StAcc;
          end
        end
        StAcc: begin
          pot_q[id_q] <= bus.add_potential;
          state_q     <= StIdle;
        end
        StSweep: begin
          if (bus.add_spike) begin
            pot_q[idx_q] <= V_RESET;
            spk_id_q     <= idx_q;
            spk_valid_q  <= 1'b1;
            state_q      <= StEmit;
          end else begin
            pot_q[idx_q] <= bus.add_potential;
            if (last_idx) state_q <= StIdle;
            else          idx_q   <= idx_q + 1'b1;
          end
        end
        StEmit: begin
          if (bus.spk_ready) begin
            spk_valid_q <= 1'b0;
            count_q     <= count_q + 1'b1;
            if (last_idx) begin
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StSweep;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
